// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared types and constants for the Genius/Simon datapath
package genius_pkg;

    // Default widths, shared with the FPGA sequence counter and the ROM
    localparam int P_DATA = 4;
    localparam int P_KEY  = 4;

    // One-hot key codes as stored in the sequence ROM
    localparam logic [3:0] KEY_GREEN  = 4'b0001;
    localparam logic [3:0] KEY_RED    = 4'b0010;
    localparam logic [3:0] KEY_BLUE   = 4'b0100;
    localparam logic [3:0] KEY_YELLOW = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_KEY,
        ST_CHECK,
        ST_WAIT_RELEASE,
        ST_DONE,
        ST_FAIL
    } seq_state_t;

endpackage

// File: rtl/key_press_detect.sv
// rtl/key_press_detect.sv - button synchronizer with press-edge detection
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   btn    raw button levels, asynchronous to clk, 1 = pressed
//   press  one-cycle pulse when any button goes from all-released to pressed
//   level  synchronized button levels (second sync stage)
module key_press_detect
    import genius_pkg::*;
#(
    parameter int p_key = P_KEY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [p_key-1:0] btn,
    output logic             press,
    output logic [p_key-1:0] level
);

    logic [p_key-1:0] s1;
    logic [p_key-1:0] s2;
    logic [p_key-1:0] s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A press is only recognised from a fully released keypad, so adding a
    // second finger to a held key never produces a new press.
    assign press = (s2 != '0) && (s3 == '0);
    assign level = s2;

endmodule

// File: rtl/user_sequence_checker.sv
// rtl/user_sequence_checker.sv - checks player key presses against the sequence ROM
//
// Ports:
//   clk       system clock, rising edge
//   R         asynchronous active-low reset
//   E         player's turn active (level); low aborts to IDLE
//   data      index of the last sequence entry to check this round
//   btn       raw button levels, 1 = pressed
//   rom_data  expected one-hot key code at address SEQUSER
//   SEQUSER   ROM address of the entry currently expected
//   key_code  last captured press
//   busy      high while waiting for / checking / releasing a key
//   tc        round completed correctly (held until E low)
//   err       wrong, invalid or missing press (held until E low)
//   timeout   err was caused by inactivity
module user_sequence_checker
    import genius_pkg::*;
#(
    parameter int p_data         = P_DATA,
    parameter int p_key          = P_KEY,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic              clk,
    input  logic              R,
    input  logic              E,
    input  logic [p_data-1:0] data,
    input  logic [p_key-1:0]  btn,
    input  logic [p_key-1:0]  rom_data,
    output logic [p_data-1:0] SEQUSER,
    output logic [p_key-1:0]  key_code,
    output logic              busy,
    output logic              tc,
    output logic              err,
    output logic              timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t        state, state_n;
    logic [p_data-1:0] seq_q, seq_n;
    logic [p_key-1:0]  key_q, key_n;
    logic [TW-1:0]     timer_q, timer_n;
    logic              last_q, last_n;
    logic              tout_q, tout_n;

    logic              press;
    logic [p_key-1:0]  level;

    key_press_detect #(.p_key(p_key)) u_detect (
        .clk   (clk),
        .rst_n (R),
        .btn   (btn),
        .press (press),
        .level (level)
    );

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state   <= ST_IDLE;
            seq_q   <= '0;
            key_q   <= '0;
            timer_q <= '0;
            last_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state   <= state_n;
            seq_q   <= seq_n;
            key_q   <= key_n;
            timer_q <= timer_n;
            last_q  <= last_n;
            tout_q  <= tout_n;
        end
    end

    always_comb begin
        state_n = state;
        seq_n   = seq_q;
        key_n   = key_q;
        timer_n = timer_q;
        last_n  = last_q;
        tout_n  = tout_q;

        if (!E) begin
            // Abort (or end of round): everything round-related returns to idle
            state_n = ST_IDLE;
            seq_n   = '0;
            timer_n = '0;
            last_n  = 1'b0;
            tout_n  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    seq_n   = '0;
                    timer_n = '0;
                    state_n = ST_WAIT_KEY;
                end
                ST_WAIT_KEY: begin
                    // A press arriving on the final timer cycle still counts
                    if (press) begin
                        key_n   = level;
                        timer_n = '0;
                        state_n = ST_CHECK;
                    end else if (timer_q == T_LAST) begin
                        tout_n  = 1'b1;
                        state_n = ST_FAIL;
                    end else begin
                        timer_n = timer_q + TW'(1);
                    end
                end
                ST_CHECK: begin
                    if (!$onehot(key_q) || (key_q != rom_data)) begin
                        tout_n  = 1'b0;
                        state_n = ST_FAIL;
                    end else if (seq_q == data) begin
                        last_n  = 1'b1;
                        state_n = ST_WAIT_RELEASE;
                    end else begin
                        seq_n   = seq_q + p_data'(1);
                        last_n  = 1'b0;
                        state_n = ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (level == '0) begin
                        timer_n = '0;
                        state_n = last_q ? ST_DONE : ST_WAIT_KEY;
                    end
                end
                ST_DONE: state_n = ST_DONE;
                ST_FAIL: state_n = ST_FAIL;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign SEQUSER  = seq_q;
    assign key_code = key_q;
    assign busy     = (state == ST_WAIT_KEY) || (state == ST_CHECK) ||
                      (state == ST_WAIT_RELEASE);
    assign tc       = (state == ST_DONE);
    assign err      = (state == ST_FAIL);
    assign timeout  = tout_q;

endmodule
